// File: rtl/vn_collector_pkg.sv
// rtl/vn_collector_pkg.sv - shared constants and helpers for the VN collector
package vn_collector_pkg;

   localparam int NUM_AS_DEF = 4;
   localparam int LANES_DEF  = 2 * NUM_AS_DEF;
   localparam int DEPTH_DEF  = 16;
   localparam int PTR_W_DEF  = $clog2(DEPTH_DEF);
   localparam int TAG_W_DEF  = $clog2(LANES_DEF);

   // Two lanes (right, left) per adder switch.
   function automatic int lanes_of(input int num_as);
      return 2 * num_as;
   endfunction

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   // A single-lane build still needs a one-bit tag field.
   function automatic int tag_w(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   function automatic logic [7:0] popcount(input logic [63:0] v);
      logic [7:0] c;
      c = '0;
      for (int i = 0; i < 64; i++) c = c + 8'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/vn_compact.sv
// rtl/vn_compact.sv - packs valid VN lanes into a dense ascending list with count
module vn_compact #(
   parameter int DATA_WIDTH = 32,
   parameter int LANES      = 8,
   parameter int TAG_W      = 3,
   parameter int N_W        = 4
) (
   input  logic [LANES*DATA_WIDTH-1:0] i_vn,
   input  logic [LANES-1:0]            i_vn_valid,
   output logic [LANES*DATA_WIDTH-1:0] o_dense,
   output logic [LANES*TAG_W-1:0]      o_lane,
   output logic [N_W-1:0]              o_n
);
   import vn_collector_pkg::*;

   int pos;

   // Walk lanes low to high, appending each valid word at the next dense slot.
   always_comb begin
      o_dense = '0;
      o_lane  = '0;
      pos     = 0;
      for (int k = 0; k < LANES; k++) begin
         if (i_vn_valid[k]) begin
            o_dense[pos*DATA_WIDTH +: DATA_WIDTH] = i_vn[k*DATA_WIDTH +: DATA_WIDTH];
            o_lane[pos*TAG_W +: TAG_W]            = TAG_W'(k);
            pos                                   = pos + 1;
         end
      end
      o_n = N_W'(popcount(64'(i_vn_valid)));
   end

endmodule

// File: rtl/vn_collector.sv
// rtl/vn_collector.sv - VN collector buffer; optional lane tags via VN_COLLECTOR_TAG_EN
module vn_collector
   import vn_collector_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_AS     = 4,
   parameter int DEPTH      = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [2*NUM_AS*DATA_WIDTH-1:0] i_vn,
   input  logic [2*NUM_AS-1:0]            i_vn_valid,
   input  logic                           i_flush,
   output logic [DATA_WIDTH-1:0]          o_data,
   output logic                           o_valid,
   input  logic                           i_ready,
   output logic [ptr_w(DEPTH):0]          o_count,
`ifdef VN_COLLECTOR_TAG_EN
   output logic [tag_w(2*NUM_AS)-1:0]     o_tag,
`endif
   output logic                           o_overflow
);
   localparam int L     = lanes_of(NUM_AS);
   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TAG_W = tag_w(L);
   localparam int N_W   = $clog2(L + 1);

   logic [L*DATA_WIDTH-1:0] w_dense;
   logic [L*TAG_W-1:0]      w_lane;
   logic [N_W-1:0]          w_n;
   logic [CNT_W-1:0]        w_free;
   logic                    w_push;
   logic                    w_drop;
   logic                    w_pop;

   logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [CNT_W-1:0]        r_count;
   logic                    r_overflow;

   vn_compact #(
      .DATA_WIDTH (DATA_WIDTH),
      .LANES      (L),
      .TAG_W      (TAG_W),
      .N_W        (N_W)
   ) u_compact (
      .i_vn       (i_vn),
      .i_vn_valid (i_vn_valid),
      .o_dense    (w_dense),
      .o_lane     (w_lane),
      .o_n        (w_n)
   );

   // Free space is judged against occupancy before this cycle's pop, so a
   // batch never relies on the slot being freed at the same edge.
   assign w_free = CNT_W'(DEPTH) - r_count;
   assign w_push = (w_n != '0) && (CNT_W'(w_n) <= w_free);
   assign w_drop = (CNT_W'(w_n) > w_free);
   assign w_pop  = (r_count != '0) && i_ready;

   // Pointers, occupancy and sticky overflow; flush outranks push and pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (i_flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(w_n);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         r_count <= r_count + (w_push ? CNT_W'(w_n) : '0) - CNT_W'(w_pop);
         if (w_drop) r_overflow <= 1'b1;
      end
   end

   // Whole batch lands at consecutive (wrapping) slots from the write pointer.
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) begin
         for (int i = 0; i < L; i++) begin
            if (N_W'(i) < w_n)
               r_mem[r_wr_ptr + PTR_W'(i)] <= w_dense[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

`ifdef VN_COLLECTOR_TAG_EN
   logic [TAG_W-1:0] r_tag_mem [DEPTH];

   // Source lane index travels alongside each stored word.
   always_ff @(posedge clk) begin
      if (w_push && !i_flush) begin
         for (int i = 0; i < L; i++) begin
            if (N_W'(i) < w_n)
               r_tag_mem[r_wr_ptr + PTR_W'(i)] <= w_lane[i*TAG_W +: TAG_W];
         end
      end
   end

   assign o_tag = o_valid ? r_tag_mem[r_rd_ptr] : '0;
`else
   logic w_unused_lane;
   assign w_unused_lane = ^w_lane;
`endif

   // Output comes straight from storage; forced to zero when empty so the
   // reset value holds without clearing the array.
   assign o_valid    = (r_count != '0);
   assign o_data     = o_valid ? r_mem[r_rd_ptr] : '0;
   assign o_count    = r_count;
   assign o_overflow = r_overflow;

endmodule

// File: tb/tb_vn_collector.sv
// tb/tb_vn_collector.sv - randomized self-checking bench for vn_collector
module tb_vn_collector;

   localparam int DW = 32;
   localparam int L  = 8;
   localparam int D  = 16;

   logic            clk;
   logic            rst_n;
   logic [L*DW-1:0] i_vn;
   logic [L-1:0]    i_vn_valid;
   logic            i_flush;
   logic [DW-1:0]   o_data;
   logic            o_valid;
   logic            i_ready;
   logic [4:0]      o_count;
   logic            o_overflow;
`ifdef VN_COLLECTOR_TAG_EN
   logic [2:0]      o_tag;
`endif

   int n_vec;
   int n_err;

   // Reference model: a FIFO of words plus the sticky drop flag.
   logic [DW-1:0] q[$];
   bit            m_ovf;

   vn_collector #(.DATA_WIDTH(DW), .NUM_AS(4), .DEPTH(D)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_vn       (i_vn),
      .i_vn_valid (i_vn_valid),
      .i_flush    (i_flush),
      .o_data     (o_data),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_count    (o_count),
`ifdef VN_COLLECTOR_TAG_EN
      .o_tag      (o_tag),
`endif
      .o_overflow (o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [L*DW-1:0] rnd_vn();
      logic [L*DW-1:0] d;
      for (int k = 0; k < L; k++) d[k*DW +: DW] = $urandom;
      return d;
   endfunction

   // Apply one cycle of stimulus, advance the model by the block's rules,
   // then land 1 ns after the clock edge.
   task automatic step(input logic [L-1:0] v, input logic [L*DW-1:0] d,
                       input logic rdy, input logic fl);
      logic [DW-1:0] batch[$];
      int free;
      i_vn       = d;
      i_vn_valid = v;
      i_ready    = rdy;
      i_flush    = fl;
      free = D - q.size();
      for (int k = 0; k < L; k++) if (v[k]) batch.push_back(d[k*DW +: DW]);
      if (fl) begin
         q.delete();
         m_ovf = 1'b0;
      end else begin
         if (rdy && q.size() != 0) void'(q.pop_front());
         if (batch.size() > 0 && batch.size() <= free) begin
            foreach (batch[i]) q.push_back(batch[i]);
         end else if (batch.size() > free) begin
            m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; i_vn = '0; i_vn_valid = '0; i_flush = 1'b0; i_ready = 1'b0;
      q.delete(); m_ovf = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (o_count !== 5'd0 || o_valid !== 1'b0 || o_overflow !== 1'b0 || o_data !== '0) begin
         n_err++;
         $display("FAIL reset: count=%0d valid=%b ovf=%b data=%h, need 0/0/0/0",
                  o_count, o_valid, o_overflow, o_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [L*DW-1:0] d;
      d = '0;
      d[0*DW +: DW] = 32'h3F80_0000;
      d[2*DW +: DW] = 32'h4000_0000;
      step(8'b0000_0101, d, 1'b1, 1'b0);
      n_vec++;
      if (o_count !== 5'd2 || o_data !== 32'h3F80_0000) begin
         n_err++;
         $display("FAIL basic0: count=%0d data=%h, need 2 3f800000", o_count, o_data);
      end
      step('0, '0, 1'b1, 1'b0);
      n_vec++;
      if (o_count !== 5'd1 || o_data !== 32'h4000_0000) begin
         n_err++;
         $display("FAIL basic1: count=%0d data=%h, need 1 40000000", o_count, o_data);
      end
      step('0, '0, 1'b1, 1'b0);
      n_vec++;
      if (o_count !== 5'd0 || o_valid !== 1'b0) begin
         n_err++;
         $display("FAIL basic2: count=%0d valid=%b, need 0 0", o_count, o_valid);
      end
   endtask

   task automatic test_full_overflow();
      step('0, '0, 1'b0, 1'b1);
      step(8'hFF, rnd_vn(), 1'b0, 1'b0);
      step(8'hFF, rnd_vn(), 1'b0, 1'b0);
      n_vec++;
      if (o_count !== 5'd16 || o_overflow !== 1'b0) begin
         n_err++;
         $display("FAIL full: count=%0d ovf=%b, need 16 0", o_count, o_overflow);
      end
      step(8'hFF, rnd_vn(), 1'b0, 1'b0);
      n_vec++;
      if (o_count !== 5'd16 || o_overflow !== 1'b1 || o_data !== q[0]) begin
         n_err++;
         $display("FAIL overflow: count=%0d ovf=%b data=%h, need 16 1 %h",
                  o_count, o_overflow, o_data, q[0]);
      end
   endtask

   task automatic test_partial_drop();
      step('0, '0, 1'b0, 1'b1);
      step(8'hFF, rnd_vn(), 1'b0, 1'b0);
      step(8'h3F, rnd_vn(), 1'b0, 1'b0);
      n_vec++;
      if (o_count !== 5'd14 || o_overflow !== 1'b0) begin
         n_err++;
         $display("FAIL fill14: count=%0d ovf=%b, need 14 0", o_count, o_overflow);
      end
      step(8'b0000_0111, rnd_vn(), 1'b1, 1'b0);
      n_vec++;
      if (o_count !== 5'd13 || o_overflow !== 1'b1 || o_data !== q[0]) begin
         n_err++;
         $display("FAIL drop3: count=%0d ovf=%b data=%h, need 13 1 %h",
                  o_count, o_overflow, o_data, q[0]);
      end
   endtask

   task automatic test_wrap();
      step('0, '0, 1'b0, 1'b1);
      step(8'hFF, rnd_vn(), 1'b0, 1'b0);
      step(8'h0F, rnd_vn(), 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         n_vec++;
         if (o_data !== q[0]) begin
            n_err++;
            $display("FAIL wrap_out%0d: data=%h, need %h", i, o_data, q[0]);
         end
         step('0, '0, 1'b1, 1'b0);
      end
      step(8'hFF, rnd_vn(), 1'b0, 1'b0);
      n_vec++;
      if (o_count !== 5'd10) begin
         n_err++;
         $display("FAIL wrap_count: count=%0d, need 10", o_count);
      end
      while (q.size() != 0) begin
         n_vec++;
         if (o_valid !== 1'b1 || o_data !== q[0]) begin
            n_err++;
            $display("FAIL wrap_drain: valid=%b data=%h, need 1 %h", o_valid, o_data, q[0]);
         end
         step('0, '0, 1'b1, 1'b0);
      end
   endtask

   task automatic test_flush();
      step('0, '0, 1'b0, 1'b1);
      step(8'hFF, rnd_vn(), 1'b0, 1'b0);
      step(8'hFF, rnd_vn(), 1'b0, 1'b0);
      step(8'hFF, rnd_vn(), 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) step('0, '0, 1'b1, 1'b0);
      n_vec++;
      if (o_count !== 5'd5 || o_overflow !== 1'b1 || o_data !== q[0]) begin
         n_err++;
         $display("FAIL preflush: count=%0d ovf=%b data=%h, need 5 1 %h",
                  o_count, o_overflow, o_data, q[0]);
      end
      step(8'hFF, rnd_vn(), 1'b1, 1'b1);
      n_vec++;
      if (o_count !== 5'd0 || o_valid !== 1'b0 || o_overflow !== 1'b0) begin
         n_err++;
         $display("FAIL flush: count=%0d valid=%b ovf=%b, need 0 0 0",
                  o_count, o_valid, o_overflow);
      end
   endtask

   task automatic test_random();
      logic [L-1:0] v;
      logic rdy;
      logic fl;
      step('0, '0, 1'b0, 1'b1);
      for (int i = 0; i < 400; i++) begin
         v   = L'($urandom);
         if (($urandom_range(0, 3)) == 0) v = '0;
         rdy = ((i / 40) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         fl  = ($urandom_range(0, 63) == 0);
         step(v, rnd_vn(), rdy, fl);
         n_vec++;
         if (o_count !== 5'(q.size()) || o_valid !== (q.size() != 0) || o_overflow !== m_ovf ||
             (q.size() != 0 && o_data !== q[0])) begin
            n_err++;
            $display("FAIL random%0d: count=%0d valid=%b ovf=%b data=%h, need %0d %b %b %h",
                     i, o_count, o_valid, o_overflow, o_data, q.size(), (q.size() != 0),
                     m_ovf, (q.size() != 0) ? q[0] : 32'h0);
         end
      end
   endtask

   task automatic test_reset_midbatch();
      logic [L*DW-1:0] d;
      step('0, '0, 1'b0, 1'b1);
      step(8'hFF, rnd_vn(), 1'b0, 1'b0);
      i_vn_valid = 8'hFF;
      i_vn       = rnd_vn();
      #2;
      rst_n = 1'b0;
      q.delete(); m_ovf = 1'b0;
      #1;
      n_vec++;
      if (o_count !== 5'd0 || o_valid !== 1'b0 || o_overflow !== 1'b0 || o_data !== '0) begin
         n_err++;
         $display("FAIL async_reset: count=%0d valid=%b ovf=%b data=%h, need 0/0/0/0",
                  o_count, o_valid, o_overflow, o_data);
      end
      i_vn_valid = '0;
      @(negedge clk);
      rst_n = 1'b1;
      d = rnd_vn();
      step(8'b0000_0011, d, 1'b1, 1'b0);
      n_vec++;
      if (o_count !== 5'd2 || o_data !== d[0 +: DW] || o_overflow !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset: count=%0d data=%h ovf=%b, need 2 %h 0",
                  o_count, o_data, o_overflow, d[0 +: DW]);
      end
   endtask

`ifdef VN_COLLECTOR_TAG_EN
   task automatic test_tag();
      logic [L*DW-1:0] d;
      d = rnd_vn();
      step('0, '0, 1'b0, 1'b1);
      step(8'b1000_0010, d, 1'b1, 1'b0);
      n_vec++;
      if (o_tag !== 3'd1 || o_data !== d[1*DW +: DW]) begin
         n_err++;
         $display("FAIL tag0: tag=%0d data=%h, need 1 %h", o_tag, o_data, d[1*DW +: DW]);
      end
      step('0, '0, 1'b1, 1'b0);
      n_vec++;
      if (o_tag !== 3'd7 || o_data !== d[7*DW +: DW]) begin
         n_err++;
         $display("FAIL tag1: tag=%0d data=%h, need 7 %h", o_tag, o_data, d[7*DW +: DW]);
      end
   endtask
`endif

   initial begin
      n_vec = 0;
      n_err = 0;
      test_reset();
      test_basic();
      test_full_overflow();
      test_partial_drop();
      test_wrap();
      test_flush();
      test_random();
      test_reset_midbatch();
`ifdef VN_COLLECTOR_TAG_EN
      test_tag();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/vn_collector.md
VN_COLLECTOR -- requirements
Module: vn_collector

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of one VN data word.
REQ-002 Parameter NUM_AS, default 4: number of upstream adder switches feeding the block; lane count L = 2*NUM_AS.
REQ-003 Parameter DEPTH, default 16: buffer entries; power of two, >= L.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_vn  input  L*DATA_WIDTH  VN words; lane k = i_vn[k*DATA_WIDTH +: DATA_WIDTH]; switch s drives lanes 2s (right) and 2s+1 (left).
REQ-007 i_vn_valid  input  L  per-lane valid; bit k qualifies lane k.
REQ-008 i_flush  input  1  synchronous clear of buffer contents.
REQ-009 o_data  output  DATA_WIDTH  head-of-buffer word.
REQ-010 o_valid  output  1  o_data holds a valid word.
REQ-011 i_ready  input  1  consumer accepts; a pop occurs when o_valid && i_ready.
REQ-012 o_count  output  log2(DEPTH)+1  current occupancy.
REQ-013 o_overflow  output  1  sticky; a batch was dropped.

Function
REQ-014 Each cycle, the valid lanes shall be compacted in ascending lane index; N = popcount(i_vn_valid).
REQ-015 If N > 0 and N <= DEPTH - o_count (occupancy before this cycle's pop), all N words shall be written at consecutive write-pointer positions at the clock edge.
REQ-016 If N > DEPTH - o_count, the entire batch shall be dropped (no partial write) and o_overflow shall be set.
REQ-017 Write/read pointers shall wrap modulo DEPTH; full is o_count == DEPTH, empty is o_count == 0.
REQ-018 o_valid shall equal (o_count != 0); o_data shall be the entry at the read pointer, registered storage, no combinational path from i_vn.
REQ-019 Latency: a word written at edge t shall be visible on o_data from the cycle after t at the earliest.
REQ-020 Simultaneous push and pop: o_count_next = o_count + N - pop; both take effect at the same edge.
REQ-021 Pop when empty shall be ignored (i_ready with o_valid low has no effect).
REQ-022 i_flush shall zero pointers and o_count and clear o_overflow; it takes priority over push and pop in the same cycle.
REQ-023 o_data shall hold its value while o_valid && !i_ready.

Reset
REQ-024 On rst_n low, asynchronously: pointers = 0, o_count = 0, o_valid = 0, o_overflow = 0, o_data = 0; storage contents need not be cleared.
REQ-025 Reset asserted mid-batch shall discard all buffered and in-flight data; first valid cycle after release shall behave as from empty.

Configuration
REQ-026 Macro VN_COLLECTOR_TAG_EN: when defined, each entry shall additionally store its source lane index and an output o_tag (log2(L) bits) shall accompany o_data, reset to 0.
REQ-027 Without VN_COLLECTOR_TAG_EN, o_tag and tag storage shall not exist; all other behaviour identical.

Structure
REQ-028 Shared package vn_collector_pkg shall hold lane-count, pointer-width and tag-width constants and a function for popcount.
REQ-029 Lane compaction (valid lanes to dense list plus count N) shall be one combinational sub-module vn_compact; storage and pointers remain in vn_collector.

Verification
REQ-030 Reset, then i_vn_valid=8'b0000_0101, lanes 0/2 = 0x3F800000/0x40000000, i_ready=1 -> o_data 0x3F800000 then 0x40000000 on consecutive cycles, o_count 2,1,0.
REQ-031 All 8 lanes valid twice with i_ready=0 -> o_count=16; third all-valid batch -> dropped, o_overflow=1, o_count stays 16.
REQ-032 o_count=14, i_vn_valid=8'b0000_0111, i_ready=1 -> batch dropped (3 > 2 free), o_overflow=1, o_count=13.
REQ-033 Fill/drain across wrap: 12 words in, 10 out, 8 in -> output order matches input order, o_count=10.
REQ-034 i_flush with o_count=5, push and pop same cycle -> o_count=0, o_valid=0, o_overflow=0 next cycle.
REQ-035 With VN_COLLECTOR_TAG_EN, i_vn_valid=8'b1000_0010 -> o_tag 1 then 7 with matching o_data.
